// File: rtl/phase_sequencer.sv
// phase_sequencer: drives the 3-bit instruction phase (1..LAST_PHASE, 0 when parked)
// with run/stop/single-step/halt control and a retired-instruction counter.
`default_nettype none

module phase_sequencer #(
  parameter int LAST_PHASE = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step,
  input  logic             hlt,
  output logic [2:0]       phase,
  output logic             running,
  output logic             paused,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] LAST = 3'(LAST_PHASE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] phase_nxt;
  logic       stop_pending, pend_nxt;
  logic       done_nxt;
  logic       start_q, step_q;
  logic       start_rise, step_rise;

  assign start_rise = start & ~start_q;
  assign step_rise  = step & ~step_q;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    pend_nxt  = stop_pending;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise && !stop) begin
          state_nxt = RUN;
          phase_nxt = 3'd1;
        end
      end
      RUN: begin
        if (stop) pend_nxt = 1'b1;
        if (phase == LAST) begin
          // Instruction retires regardless of where it goes next.
          done_nxt = 1'b1;
          pend_nxt = 1'b0;
          if (hlt) begin
            state_nxt = HALTED;
            phase_nxt = 3'd0;
          end else if (stop_pending || stop) begin
            state_nxt = IDLE;
            phase_nxt = 3'd0;
          end else if (step_mode) begin
            state_nxt = PAUSE;
            phase_nxt = 3'd0;
          end else begin
            phase_nxt = 3'd1;
          end
        end else begin
          phase_nxt = phase + 3'd1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (step_rise || !step_mode) begin
          state_nxt = RUN;
          phase_nxt = 3'd1;
        end
      end
      HALTED: begin
        phase_nxt = 3'd0;
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= 3'd0;
      stop_pending <= 1'b0;
      start_q      <= 1'b0;
      step_q       <= 1'b0;
      running      <= 1'b0;
      paused       <= 1'b0;
      halted       <= 1'b0;
      instr_done   <= 1'b0;
      instr_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      stop_pending <= pend_nxt;
      start_q      <= start;
      step_q       <= step;
      running      <= (state_nxt == RUN);
      paused       <= (state_nxt == PAUSE);
      halted       <= (state_nxt == HALTED);
      instr_done   <= done_nxt;
      if (done_nxt) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire
